kamikaze_prefetch: RTL and testbench

KAMIKAZE_PREFETCH -- requirements
Module: kamikaze_prefetch

---
 rtl/kamikaze_prefetch.sv | 116 +++++++++++
 tb/tb_kamikaze_prefetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/kamikaze_prefetch.sv
// Instruction prefetch queue: fetches sequential words from instruction memory
// into a small FIFO ahead of the fetch stage, flushing on branch redirects.
//
// Handshakes:
//   memory side : a word transfers when im_req_o && im_ack_i in the same cycle.
//                 im_addr_o does not move while a request is pending and
//                 unacknowledged; a request may be withdrawn (redirect) before
//                 it is acknowledged.
//   fetch side  : the head word transfers when word_valid_o && word_ready_i.
//                 word_ready_i with an empty queue is ignored.
module kamikaze_prefetch #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic                       im_req_o,
  output logic [31:0]                im_addr_o,
  input  logic                       im_ack_i,
  input  logic [31:0]                im_data_i,
  output logic [31:0]                word_o,
  output logic [31:0]                word_addr_o,
  output logic                       word_valid_o,
  input  logic                       word_ready_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  // Low for the first cycle after reset so no request overlaps reset release.
  logic          run_q, run_d;

  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   addr_mem_q [DEPTH];

  logic          push;
  logic          pop;
  logic          unused_pc_bits;

  // The redirect target is word aligned by dropping its low bits.
  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // Request only from registered occupancy so a same-cycle pop cannot
  // open a slot in a full queue.
  assign im_req_o     = run_q && (count_q < CW'(DEPTH)) && !redirect_i;
  assign im_addr_o    = addr_q;
  assign push         = im_req_o && im_ack_i;
  assign word_valid_o = (count_q != '0);
  assign pop          = word_valid_o && word_ready_i && !redirect_i;
  assign count_o      = count_q;

  // Head outputs come only from stored queue state; zero while empty.
  assign word_o      = word_valid_o ? data_mem_q[head_q] : 32'h0;
  assign word_addr_o = word_valid_o ? addr_mem_q[head_q] : 32'h0;

  // Next-state for pointers, occupancy and fetch address; redirect wins.
  always_comb begin
    run_d   = 1'b1;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    if (redirect_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      addr_d  = {redirect_pc_i[31:2], 2'b00};
    end else begin
      if (push) begin
        tail_d = tail_q + PW'(1);
        addr_d = addr_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run_q   <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      addr_q  <= RESET_ADDR;
    end else begin
      run_q   <= run_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
    end
  end

  // Queue storage; contents are only observable while counted as valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem_q[tail_q] <= im_data_i;
      addr_mem_q[tail_q] <= addr_q;
    end
  end

endmodule

// File: tb/tb_kamikaze_prefetch.sv
// Bench for kamikaze_prefetch: directed scenarios plus random traffic,
// checked against a reference queue of {address, data} entries.
module tb_kamikaze_prefetch;

  localparam int          DEPTH      = 4;
  localparam logic [31:0] RESET_ADDR = 32'h0;

  logic        clk_i;
  logic        rst_i;
  logic        im_req_o;
  logic [31:0] im_addr_o;
  logic        im_ack_i;
  logic [31:0] im_data_i;
  logic [31:0] word_o;
  logic [31:0] word_addr_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [2:0]  count_o;

  kamikaze_prefetch #(.DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .im_req_o      (im_req_o),
    .im_addr_o     (im_addr_o),
    .im_ack_i      (im_ack_i),
    .im_data_i     (im_data_i),
    .word_o        (word_o),
    .word_addr_o   (word_addr_o),
    .word_valid_o  (word_valid_o),
    .word_ready_i  (word_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .count_o       (count_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr;
  logic        exp_run;
  int          n_total;
  int          n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ack, input logic rdy, input logic redir,
                       input logic [31:0] pc);
    @(posedge clk_i);
    #1;
    im_ack_i      = ack;
    word_ready_i  = rdy;
    redirect_i    = redir;
    redirect_pc_i = pc;
    im_data_i     = $urandom;
  endtask

  task automatic assert_reset();
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    exp_q.delete();
    exp_run  = 1'b0;
    exp_addr = RESET_ADDR;
    #1;
    check("rst_req",   {63'd0, im_req_o},     64'd0);
    check("rst_count", {61'd0, count_o},      64'd0);
    check("rst_valid", {63'd0, word_valid_o}, 64'd0);
    check("rst_word",  {32'd0, word_o},       64'd0);
    check("rst_waddr", {32'd0, word_addr_o},  64'd0);
    check("rst_iaddr", {32'd0, im_addr_o},    {32'd0, RESET_ADDR});
  endtask

  task automatic release_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Inputs change just after the rising edge, so the falling edge sees the
  // values that the next rising edge will act on.
  always @(negedge clk_i) begin
    logic        e_req;
    logic [63:0] head;
    if (!rst_i) begin
      check("in_rst_req",   {63'd0, im_req_o},     64'd0);
      check("in_rst_count", {61'd0, count_o},      64'd0);
      check("in_rst_valid", {63'd0, word_valid_o}, 64'd0);
    end else begin
      e_req = exp_run && (exp_q.size() < DEPTH) && !redirect_i;
      check("req",   {63'd0, im_req_o},     {63'd0, e_req});
      check("count", {61'd0, count_o},      64'(exp_q.size()));
      check("valid", {63'd0, word_valid_o}, {63'd0, exp_q.size() != 0});
      check("iaddr", {32'd0, im_addr_o},    {32'd0, exp_addr});
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check("waddr", {32'd0, word_addr_o}, {32'd0, head[63:32]});
        check("word",  {32'd0, word_o},      {32'd0, head[31:0]});
      end else begin
        check("waddr_empty", {32'd0, word_addr_o}, 64'd0);
        check("word_empty",  {32'd0, word_o},      64'd0);
      end
      if (redirect_i) begin
        exp_q.delete();
        exp_addr = {redirect_pc_i[31:2], 2'b00};
      end else begin
        if (exp_q.size() != 0 && word_ready_i) void'(exp_q.pop_front());
        if (e_req && im_ack_i) begin
          exp_q.push_back({exp_addr, im_data_i});
          exp_addr = exp_addr + 32'd4;
        end
      end
      exp_run = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_total       = 0;
    n_bad         = 0;
    exp_run       = 1'b0;
    exp_addr      = RESET_ADDR;
    rst_i         = 1'b0;
    im_ack_i      = 1'b0;
    im_data_i     = 32'h0;
    word_ready_i  = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    repeat (3) @(posedge clk_i);

    // Fill from reset: requests 0,4,8,12 then stop when full.
    im_ack_i = 1'b1;
    release_reset();
    repeat (7) drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("fill_count", {61'd0, count_o},  64'd4);
    check("fill_req",   {63'd0, im_req_o}, 64'd0);
    check("fill_iaddr", {32'd0, im_addr_o}, 64'd16);
    check("fill_head",  {32'd0, word_addr_o}, 64'd0);

    // Full queue with a single pop: request resumes next cycle at 16.
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("refill_req",  {63'd0, im_req_o},  64'd1);
    check("refill_addr", {32'd0, im_addr_o}, 64'd16);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h0);

    // Drain, then stream with continuous ack and ready.
    repeat (5) drive(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (20) drive(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect while three words are queued.
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0106);
    @(negedge clk_i);
    check("redir_req_off", {63'd0, im_req_o}, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("redir_count", {61'd0, count_o},   64'd0);
    check("redir_addr",  {32'd0, im_addr_o}, 64'h104);
    check("redir_req",   {63'd0, im_req_o},  64'd1);

    // Address wrap at the top of memory.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (4) drive(1'b1, 1'b1, 1'b0, 32'h0);

    // Stall with a pending request, then reset in the middle of it.
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    repeat (5) drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("stall_addr", {32'd0, im_addr_o}, 64'h200);
    assert_reset();
    repeat (2) @(posedge clk_i);
    release_reset();

    // Random traffic with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        assert_reset();
        release_reset();
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0, $urandom);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
